// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display path.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package display_pkg;
  localparam int NUM_DIGITS = 8;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/reg_display_scan_if.sv
// Register taps in, display pins out.
// No handshake: every input is a level, sampled on every clk edge; outputs are registered levels.
interface reg_display_scan_if;
  import display_pkg::*;

  logic [7:0]            reg0;
  logic [7:0]            reg1;
  logic [7:0]            reg2;
  logic [7:0]            reg3;
  logic                  blank;
  logic                  hl_en;
  logic [1:0]            hl_sel;
  logic [NUM_DIGITS-1:0] an_n;
  logic [6:0]            seg_n;
  logic                  dp_n;

  modport master (
    output reg0, reg1, reg2, reg3, blank, hl_en, hl_sel,
    input  an_n, seg_n, dp_n
  );

  modport slave (
    input  reg0, reg1, reg2, reg3, blank, hl_en, hl_sel,
    output an_n, seg_n, dp_n
  );
endinterface

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_OFF;
    seg_n = SEG_LUT[nibble];
  end

endmodule

// File: rtl/reg_display_scan.sv
// 8-digit multiplexed hex scanner for the four general registers.
// Registers are snapshotted at the start of each frame so a digit pair never tears.
module reg_display_scan
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 500
) (
  input  logic               clk,
  input  logic               rst,
  reg_display_scan_if.slave  bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] GUARD_C  = DIV_W'(GUARD);

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [2:0]            digit_q, digit_d;
  logic [7:0]            snap_q [4];
  logic [7:0]            snap_d [4];
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic [6:0]            seg_n_q, seg_n_d;
  logic                  dp_n_q, dp_n_d;

  logic [7:0]            cur_snap;
  logic [3:0]            cur_nibble;
  logic                  an_active;

  hex_to_7seg u_hex (
    .nibble (cur_nibble),
    .seg_n  (seg_n_d)
  );

  always_comb begin
    div_cnt_d  = div_cnt_q + DIV_W'(1);
    digit_d    = digit_q;
    snap_d     = snap_q;
    cur_snap   = snap_q[digit_q[2:1]];
    cur_nibble = digit_q[0] ? cur_snap[7:4] : cur_snap[3:0];
    an_active  = 1'b0;
    an_n_d     = '1;
    dp_n_d     = 1'b1;

    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      digit_d   = digit_q + 3'd1;
    end

    // Frame start: capture what the register file holds before this edge.
    if (digit_q == 3'd0 && div_cnt_q == '0) begin
      snap_d[0] = bus.reg0;
      snap_d[1] = bus.reg1;
      snap_d[2] = bus.reg2;
      snap_d[3] = bus.reg3;
    end

    // The guard window at slot start keeps the previous digit from ghosting.
    if (div_cnt_q >= GUARD_C && !bus.blank) begin
      an_active = 1'b1;
      an_n_d    = ~(NUM_DIGITS'(1) << digit_q);
    end

    if (bus.hl_en && digit_q == {bus.hl_sel, 1'b1} && an_active) begin
      dp_n_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      digit_q   <= '0;
      for (int i = 0; i < 4; i++) snap_q[i] <= '0;
      an_n_q    <= '1;
      seg_n_q   <= 7'h40;
      dp_n_q    <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      digit_q   <= digit_d;
      snap_q    <= snap_d;
      an_n_q    <= an_n_d;
      seg_n_q   <= seg_n_d;
      dp_n_q    <= dp_n_d;
    end
  end

  assign bus.an_n  = an_n_q;
  assign bus.seg_n = seg_n_q;
  assign bus.dp_n  = dp_n_q;

endmodule

// File: tb/tb_reg_display_scan.sv
// Bench for reg_display_scan: directed test-plan scenarios then random traffic,
// checked cycle by cycle against a cycle-count based model of the display.
module tb_reg_display_scan;

  localparam int SD = 4;
  localparam int GD = 1;

  logic clk;
  logic rst;

  reg_display_scan_if bus ();

  reg_display_scan #(
    .SCAN_DIV (SD),
    .GUARD    (GD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int n      = 0;      // edges since reset released
  logic [7:0]  m_snap [4];
  logic [15:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", tag, got, exp, n);
    end
  endtask

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 7'h40;  4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;  4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;  4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;  4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;  4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;  4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;  4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;  default: hex_seg = 7'h0E;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Inputs held now are what the next edge samples; outputs are checked 1 time unit after it.
  task automatic step();
    logic [7:0]  r [4];
    logic        b, he, rs;
    logic [1:0]  hs;
    int          d, pos;
    logic [3:0]  nib;
    logic        lit;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [15:0] e;
    r[0] = bus.reg0; r[1] = bus.reg1; r[2] = bus.reg2; r[3] = bus.reg3;
    b = bus.blank; he = bus.hl_en; hs = bus.hl_sel; rs = rst;
    @(posedge clk);
    #1;
    if (rs) begin
      n = 0;
      for (int i = 0; i < 4; i++) m_snap[i] = 8'h00;
      e_an = 8'hFF; e_seg = 7'h40; e_dp = 1'b1;
    end else begin
      d     = (n / SD) % 8;
      pos   = n % SD;
      nib   = (d % 2 == 1) ? m_snap[d / 2][7:4] : m_snap[d / 2][3:0];
      lit   = (pos >= GD) && !b;
      e_an  = lit ? ~(8'd1 << d) : 8'hFF;
      e_seg = hex_seg(nib);
      e_dp  = !(he && d == 2 * int'(hs) + 1 && lit);
      if (n % (8 * SD) == 0) for (int i = 0; i < 4; i++) m_snap[i] = r[i];
      n++;
    end
    exp_q.push_back({e_an, e_seg, e_dp});
    e = exp_q.pop_front();
    check("an_n",  32'(bus.an_n),  32'(e[15:8]));
    check("seg_n", 32'(bus.seg_n), 32'(e[7:1]));
    check("dp_n",  32'(bus.dp_n),  32'(e[0]));
  endtask

  task automatic set_regs(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    bus.reg0 = a; bus.reg1 = b; bus.reg2 = c; bus.reg3 = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    set_regs(8'h12, 8'h34, 8'h56, 8'h78);
    bus.blank = 1'b0; bus.hl_en = 1'b0; bus.hl_sel = 2'd0;

    // Reset and first full frame
    repeat (3) step();
    rst = 1'b0;
    repeat (32) step();

    // Tear-free: change reg0 while digit 3 is lit in frame 2
    while (n != 32 + 3 * SD + 1) step();
    bus.reg0 = 8'hAF;
    while (n != 96) step();

    // Highlight on register 2, then off
    bus.hl_en = 1'b1; bus.hl_sel = 2'd2;
    repeat (32) step();
    bus.hl_en = 1'b0;
    repeat (32) step();

    // Blank window, then a one-cycle reset in the middle of digit 6
    bus.blank = 1'b1;
    repeat (10) step();
    bus.blank = 1'b0;
    while ((n / SD) % 8 != 6) step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_regs(8'h9C, 8'hDE, 8'h0B, 8'h47);
    repeat (40) step();

    // Random traffic
    for (int k = 0; k < 700; k++) begin
      if ($urandom_range(0, 5) == 0)
        set_regs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      bus.blank  = ($urandom_range(0, 7) == 0);
      bus.hl_en  = 1'($urandom_range(0, 1));
      bus.hl_sel = 2'($urandom_range(0, 3));
      rst        = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_display_scan.md
# reg_display_scan

Time-multiplexed 8-digit seven-segment scanner. It shows the four 8-bit general registers as hex on the board display, two digits per register, and sits directly downstream of the register file's `outReg0..outReg3` taps. Register values are snapshotted once per frame so the display never shows a half-updated value. A guard interval at the start of each digit slot blanks all anodes to suppress ghosting.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clk cycles per digit slot; legal range ≥ 2.
- `GUARD`, default 500: blanked cycles at the start of each slot; legal range 1 ≤ GUARD < SCAN_DIV.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `reg0`..`reg3`  in  8 each  live register file contents
- `blank`  in  1  when 1, all anodes off
- `hl_en`  in  1  enables the highlight decimal point
- `hl_sel`  in  2  register whose high-nibble digit lights the decimal point
- `an_n`  out  8  digit anodes, active-low; bit k = digit k, digit 0 rightmost
- `seg_n`  out  7  segments {g,f,e,d,c,b,a}, active-low
- `dp_n`  out  1  decimal point, active-low

## Operation
- State: `div_cnt` (0..SCAN_DIV-1), `digit` (0..7), `snap[0..3]` (8 bits each).
- `div_cnt` increments every cycle and wraps at SCAN_DIV-1. On the wrap, `digit` increments mod 8.
- Snapshot: on any edge where `digit==0 && div_cnt==0`, `snap[i] <= reg_i` for all i. This occurs on the first edge after reset release and then once per frame.
- Digit mapping: digit k shows `snap[k>>1]`. Even k shows the low nibble, odd k shows the high nibble. So digits 1:0 show reg0 and digits 7:6 show reg3.
- Hex decode, active-low: 0→0x40, 1→0x79, 2→0x24, 3→0x30, 4→0x19, 5→0x12, 6→0x02, 7→0x78, 8→0x00, 9→0x10, A→0x08, b→0x03, C→0x46, d→0x21, E→0x06, F→0x0E.
- Anode output:
  - `an_n = ~(8'b1 << digit)`.
  - It is forced to 0xFF if `div_cnt < GUARD` or if `blank==1`.
- Decimal point: `dp_n = 0` only when all of the following hold; otherwise 1:
  - `hl_en==1`
  - `digit == 2*hl_sel+1`
  - the anode is active.
- During guard or blank, `seg_n` and `dp_n` still present the current digit's values. Only the anodes gate visibility.
- `blank` and `hl_*` affect outputs only; they do not stall the counters or the snapshot.

## Timing
- All outputs are registered. Outputs after edge N reflect `digit`, `div_cnt`, `snap`, `blank` and `hl_*` as held during cycle N, so inputs have 1-cycle latency to the pins.
- Reset values:
  - `an_n=0xFF`, `seg_n=0x40`, `dp_n=1`
  - `div_cnt=0`, `digit=0`, `snap=0`
- Frame period is 8·SCAN_DIV cycles. Each digit is lit for SCAN_DIV−GUARD cycles.
- A register change becomes visible at the next snapshot, at most 8·SCAN_DIV+1 cycles later. A change never shows mid-frame.
- Reset asserted mid-frame takes effect on the next edge: counters restart at 0 and anodes go off. This applies even if reset lasts one cycle.
- `reg_i` changing on the same edge as a snapshot: the value sampled is the one held before that edge.
- Since GUARD ≥ 1, digit 0 is never lit before its snapshot has updated.

## Structure
- Shared package `display_pkg`:
  - 16-entry `SEG_LUT` constant, active-low, {g..a}
  - `NUM_DIGITS=8`
  - `SEG_OFF=7'h7F`
- Sub-module `hex_to_7seg` (4-bit in, 7-bit active-low out), purely combinational from `SEG_LUT`. Instantiated once on the selected nibble.
- Counter widths: `$clog2(SCAN_DIV)` for `div_cnt`, 3 bits for `digit`.

## Test plan
Bench parameters: SCAN_DIV=4, GUARD=1.
- **Reset:** hold `rst` 3 cycles with `reg0..3 = 0x12,0x34,0x56,0x78` → `an_n=0xFF`, `seg_n=0x40`, `dp_n=1` during reset.
- **Full frame:** release reset with the same values → over 32 cycles each digit k is lit for 3 cycles, with `seg_n` following the nibbles 2,1,4,3,6,5,8,7 (0x24,0x79,0x19,0x30,0x02,0x12,0x00,0x78). `an_n=0xFF` on the first cycle of each slot.
- **Tear-free snapshot:** change `reg0` 0x12→0xAF while digit 3 is active → digits 1:0 still show 2,1 for the rest of the frame, then show F,A (0x0E,0x08) in the next frame.
- **Highlight:** `hl_en=1`, `hl_sel=2` → `dp_n=0` only while digit 5 is lit. `hl_en=0` → `dp_n=1` always.
- **Blank and mid-frame reset:** `blank=1` for 10 cycles → `an_n=0xFF` throughout while counters keep running. Then pulse `rst` at digit 6 → `an_n=0xFF` next cycle and scanning restarts at digit 0 with a new snapshot.
